sparkle_spot_gen: RTL
=====================

Name: sparkle_spot_gen

Overview:
- Producer side of the sparkle sprite interface: drives `sparkle_here` and `sparkle_pixel` into the sparkle animation reader.
- Tracks the current VGA scan position against a 20x20 sparkle box placed near an anchor point (wand tip), with per-spawn pseudo-random jitter and a fixed lifetime in frames.
- Sits between the VGA timing controller and the sparkle reader in the pixel pipeline.

Parameters:
- SIZE, 20: sparkle box edge in pixels; `sparkle_pixel` range is 0..SIZE*SIZE-1.
- H_RES, 640: visible width used for clamping.
- V_RES, 480: visible height used for clamping.
- LIFE, 8: frame_ticks per spawn before re-spawn.
- SEED, 8'hA5: LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system pixel clock.
- reset  in  1  synchronous, active-high reset.
- vga_x  in  10  current scan column.
- vga_y  in  10  current scan row.
- frame_tick  in  1  one-cycle pulse at start of vertical blank.
- enable  in  1  level request to show sparkles.
- anchor_x  in  10  sparkle centre column.
- anchor_y  in  10  sparkle centre row.
- sparkle_here  out  1  current pixel lies inside the active box.
- sparkle_pixel  out  12  row-major index within the box; 0 when sparkle_here=0.
- active  out  1  FSM in SHOW.

Behaviour:
- Clock and reset: one clock, `clk`. `reset` is synchronous and active-high, sampled on posedge `clk`.
- Reset values:
  - state=IDLE; sparkle_here=0, sparkle_pixel=0, active=0.
  - lfsr=SEED; pos_x=pos_y=0; life_cnt=0.
  - Applies identically when asserted mid-SHOW; takes effect on the next edge.
- LFSR:
  - 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1. Shift left; new LSB = b7^b5^b4^b3.
  - Advances only on cycles with frame_tick=1.
  - Never reaches 0.
- Spawn computation (combinational on the current lfsr, before it advances):
  - jx = lfsr[3:0] - 8; jy = lfsr[7:4] - 8 (signed, -8..+7).
  - cx = anchor_x - SIZE/2 + jx; cy = anchor_y - SIZE/2 + jy, in 12-bit signed arithmetic.
  - Clamp cx to [0, H_RES-SIZE] and cy to [0, V_RES-SIZE].
  - Load the clamped values into pos_x/pos_y.
- FSM (transitions only on frame_tick=1):
  - IDLE: if enable, spawn, set life_cnt=LIFE-1, go to SHOW. Else stay.
  - SHOW, enable=0: go to IDLE; pos unchanged.
  - SHOW, enable=1, life_cnt=0: re-spawn, set life_cnt=LIFE-1, stay in SHOW.
  - SHOW, enable=1, life_cnt>0: decrement life_cnt.
  - pos_x/pos_y change only at frame_tick, so no tearing within a frame.
- Hit test:
  - hit = (state==SHOW) && vga_x in [pos_x, pos_x+SIZE-1] && vga_y in [pos_y, pos_y+SIZE-1], inclusive bounds.
- Outputs:
  - Registered, one-cycle latency from vga_x/vga_y.
  - sparkle_pixel = (vga_y-pos_y)*SIZE + (vga_x-pos_x), zero-extended to 12 bits. Maximum 399 at SIZE=20.
  - When hit=0: sparkle_here=0, sparkle_pixel=0.
  - active = (state==SHOW), registered.
- Other rules:
  - frame_tick while enable toggles: the level sampled on the tick edge decides.
  - anchor changes between ticks have no effect until the next spawn.

Test Plan:
- Reset hold 3 cycles, then release with enable=0, 5 frame_ticks -> active=0, sparkle_here=0 throughout; lfsr advanced 5 steps from 8'hA5.
- Spawn and scan:
  - Stimulus: enable=1, anchor=(100,100), lfsr=8'hA5 at tick (jx=-3, jy=+2).
  - Required: pos=(87,92).
  - Scan (87,92) -> one cycle later sparkle_here=1, pixel=0.
  - Scan (106,111) -> pixel=399.
  - Scan (107,92) -> sparkle_here=0, pixel=0.
- Clamp, anchor=(2,470), any lfsr:
  - pos_x=0.
  - pos_y=460 whenever the computed cy>460.
  - Scan (0,479) -> pixel=380+0=380.
- Lifetime, LIFE=8, enable held:
  - Position constant for 8 frame_ticks.
  - Re-spawn on the 9th tick with the new lfsr value.
  - active stays 1 throughout.
- Disable mid-SHOW at life_cnt=4 -> IDLE on the next tick; active=0 and sparkle_here=0 from then on.
- Synchronous reset asserted mid-scan inside the box -> next edge: sparkle_here=0, active=0, lfsr=8'hA5.

Source files
------------

// File: rtl/sparkle_spot_gen.sv
// Sparkle sprite producer: places a jittered SIZE x SIZE box near an anchor,
// re-spawns it every LIFE frames and reports hit / row-major pixel index per scan position.
module sparkle_spot_gen #(
    parameter int          SIZE  = 20,
    parameter int          H_RES = 640,
    parameter int          V_RES = 480,
    parameter int          LIFE  = 8,
    parameter logic [7:0]  SEED  = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  vga_x,
    input  logic [9:0]  vga_y,
    input  logic        frame_tick,
    input  logic        enable,
    input  logic [9:0]  anchor_x,
    input  logic [9:0]  anchor_y,
    output logic        sparkle_here,
    output logic [11:0] sparkle_pixel,
    output logic        active
);

    typedef enum logic {IDLE, SHOW} state_t;

    localparam int                LW        = (LIFE > 1) ? $clog2(LIFE) : 1;
    localparam logic [LW-1:0]     LIFE_LOAD = LW'(LIFE - 1);
    localparam logic signed [11:0] HALF     = 12'(SIZE / 2);
    localparam logic signed [11:0] MAX_X    = 12'(H_RES - SIZE);
    localparam logic signed [11:0] MAX_Y    = 12'(V_RES - SIZE);
    localparam logic [10:0]       SPAN      = 11'(SIZE - 1);
    localparam logic [11:0]       SIZE12    = 12'(SIZE);

    state_t          state, state_d;
    logic [7:0]      lfsr, lfsr_d;
    logic [9:0]      pos_x, pos_y, pos_x_d, pos_y_d;
    logic [LW-1:0]   life_cnt, life_d;
    logic signed [11:0] jx, jy, cx, cy;
    logic [9:0]      spawn_x, spawn_y;
    logic            hit;
    logic [9:0]      dx, dy;
    logic [11:0]     pix;

    // Spawn position from the pre-advance LFSR: nibbles become -8..+7 jitter, then clamp on screen
    always_comb begin
        jx = $signed({8'd0, lfsr[3:0]}) - 12'sd8;
        jy = $signed({8'd0, lfsr[7:4]}) - 12'sd8;
        cx = $signed({2'b00, anchor_x}) - HALF + jx;
        cy = $signed({2'b00, anchor_y}) - HALF + jy;
        spawn_x = cx[9:0];
        spawn_y = cy[9:0];
        if (cx < 12'sd0)
            spawn_x = 10'd0;
        else if (cx > MAX_X)
            spawn_x = MAX_X[9:0];
        if (cy < 12'sd0)
            spawn_y = 10'd0;
        else if (cy > MAX_Y)
            spawn_y = MAX_Y[9:0];
    end

    always_comb begin
        state_d = state;
        lfsr_d  = lfsr;
        pos_x_d = pos_x;
        pos_y_d = pos_y;
        life_d  = life_cnt;
        if (frame_tick) begin
            lfsr_d = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            case (state)
                IDLE: begin
                    if (enable) begin
                        state_d = SHOW;
                        life_d  = LIFE_LOAD;
                        pos_x_d = spawn_x;
                        pos_y_d = spawn_y;
                    end
                end
                default: begin
                    if (!enable) begin
                        state_d = IDLE;
                    end else if (life_cnt == '0) begin
                        life_d  = LIFE_LOAD;
                        pos_x_d = spawn_x;
                        pos_y_d = spawn_y;
                    end else begin
                        life_d = life_cnt - LW'(1);
                    end
                end
            endcase
        end
    end

    // Widen to 11 bits so pos + SPAN cannot wrap near the right/bottom edge
    always_comb begin
        hit = (state == SHOW) &&
              ({1'b0, vga_x} >= {1'b0, pos_x}) && ({1'b0, vga_x} <= {1'b0, pos_x} + SPAN) &&
              ({1'b0, vga_y} >= {1'b0, pos_y}) && ({1'b0, vga_y} <= {1'b0, pos_y} + SPAN);
        dx  = vga_x - pos_x;
        dy  = vga_y - pos_y;
        pix = {2'b00, dy} * SIZE12 + {2'b00, dx};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            lfsr          <= SEED;
            pos_x         <= '0;
            pos_y         <= '0;
            life_cnt      <= '0;
            sparkle_here  <= 1'b0;
            sparkle_pixel <= '0;
            active        <= 1'b0;
        end else begin
            state         <= state_d;
            lfsr          <= lfsr_d;
            pos_x         <= pos_x_d;
            pos_y         <= pos_y_d;
            life_cnt      <= life_d;
            sparkle_here  <= hit;
            sparkle_pixel <= hit ? pix : 12'd0;
            active        <= (state_d == SHOW);
        end
    end

endmodule
